// File: rtl/hsl_to_rgb_pkg.sv
// Shared definitions for the HSL-to-RGB colour pipeline.
//   LATENCY       : clocks from input strobe to valid_o pulse.
//   chan_sel_e    : per-channel source select (zero, chroma, second largest).
//   sector_map    : hue sector -> (r', g', b') source selects.
//   div255_round  : round(x/255) for x <= 65025, divider-free.
//   sat_add8      : 8-bit add clamped at 255.
package hsl_to_rgb_pkg;

  localparam int unsigned LATENCY = 4;

  typedef enum logic [1:0] {
    CH_ZERO = 2'd0,
    CH_C    = 2'd1,
    CH_X    = 2'd2
  } chan_sel_e;

  typedef struct packed {
    chan_sel_e r;
    chan_sel_e g;
    chan_sel_e b;
  } sector_map_t;

  function automatic sector_map_t sector_map(input logic [2:0] sector);
    sector_map_t m;
    m = '{r: CH_ZERO, g: CH_ZERO, b: CH_ZERO};
    case (sector)
      3'd0: m = '{r: CH_C,    g: CH_X,    b: CH_ZERO};
      3'd1: m = '{r: CH_X,    g: CH_C,    b: CH_ZERO};
      3'd2: m = '{r: CH_ZERO, g: CH_C,    b: CH_X   };
      3'd3: m = '{r: CH_ZERO, g: CH_X,    b: CH_C   };
      3'd4: m = '{r: CH_X,    g: CH_ZERO, b: CH_C   };
      3'd5: m = '{r: CH_C,    g: CH_ZERO, b: CH_X   };
      default: m = '{r: CH_ZERO, g: CH_ZERO, b: CH_ZERO};
    endcase
    return m;
  endfunction

  // t = x + 128; result = (t + (t >> 8)) >> 8. 17 bits hold the worst case.
  function automatic logic [7:0] div255_round(input logic [15:0] x);
    logic [16:0] t;
    logic [16:0] u;
    t = {1'b0, x} + 17'd128;
    u = t + (t >> 8);
    return 8'(u >> 8);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/mul_div255.sv
// 8x8 unsigned multiply followed by round(product/255), registered.
//   clock, reset : rising-edge clock, asynchronous active-high reset.
//   a, b         : 8-bit unsigned operands.
//   p            : registered round(a*b/255), valid one clock after a/b.
module mul_div255
  import hsl_to_rgb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [15:0] prod;
  logic [7:0]  p_d;
  logic [7:0]  p_q;

  always_comb begin
    prod = 16'(a) * 16'(b);
    p_d  = div255_round(prod);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/hsl_to_rgb.sv
// Four-stage pipelined HSL -> RGB converter, one triple per clock, no stall.
//   clock, reset : rising-edge clock, asynchronous active-high reset.
//   h, s, l      : 8-bit hue (full circle = 256), saturation, lightness.
//   ready_i      : input strobe; h/s/l sampled on edges where it is high.
//   r, g, b      : 8-bit result, held between valid pulses.
//   valid_o      : one-cycle pulse per accepted input, LATENCY clocks later.
module hsl_to_rgb
  import hsl_to_rgb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] h,
  input  logic [7:0] s,
  input  logic [7:0] l,
  input  logic       ready_i,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       valid_o
);

  // Stage valid bits; bit k marks stage k+1 holding a live sample.
  logic [LATENCY-1:0] vld_d, vld_q;

  // Stage 1
  logic [8:0]  two_l;
  logic [10:0] h6;
  logic [7:0]  d1_d, d1_q;
  logic [2:0]  sector1_d, sector1_q;
  logic [7:0]  f1_d, f1_q;
  logic [7:0]  s1_d, s1_q;
  logic [7:0]  l1_d, l1_q;

  // Stage 2 (chroma is registered inside the multiplier)
  logic [7:0]  chroma_a;
  logic [7:0]  c2;
  logic [7:0]  hp2_d, hp2_q;
  logic [7:0]  l2_d, l2_q;
  logic [2:0]  sector2_d, sector2_q;

  // Stage 3 (x is registered inside the multiplier)
  logic [7:0]  x3;
  logic [7:0]  m3_d, m3_q;
  logic [7:0]  c3_d, c3_q;
  logic [2:0]  sector3_d, sector3_q;

  // Stage 4
  sector_map_t sel;
  logic [7:0]  rp, gp, bp;
  logic [7:0]  r_d, r_q;
  logic [7:0]  g_d, g_q;
  logic [7:0]  b_d, b_q;

  function automatic logic [7:0] pick(input chan_sel_e cs, input logic [7:0] c,
                                      input logic [7:0] x);
    logic [7:0] v;
    case (cs)
      CH_C:    v = c;
      CH_X:    v = x;
      default: v = '0;
    endcase
    return v;
  endfunction

  mul_div255 u_chroma (
    .clock (clock),
    .reset (reset),
    .a     (chroma_a),
    .b     (s1_q),
    .p     (c2)
  );

  mul_div255 u_second (
    .clock (clock),
    .reset (reset),
    .a     (c2),
    .b     (hp2_q),
    .p     (x3)
  );

  always_comb begin
    vld_d = {vld_q[LATENCY-2:0], ready_i};

    // Stage 1: d = |2l - 255|, hue split into sector and fraction.
    two_l     = {l, 1'b0};
    d1_d      = (two_l >= 9'd255) ? 8'(two_l - 9'd255) : 8'(9'd255 - two_l);
    h6        = 11'(h) * 11'd6;
    sector1_d = h6[10:8];
    f1_d      = h6[7:0];
    s1_d      = s;
    l1_d      = l;

    // Stage 2: odd sectors ramp downward.
    chroma_a  = 8'd255 - d1_q;
    hp2_d     = sector1_q[0] ? (8'd255 - f1_q) : f1_q;
    l2_d      = l1_q;
    sector2_d = sector1_q;

    // Stage 3
    m3_d      = l2_q - {1'b0, c2[7:1]};
    c3_d      = c2;
    sector3_d = sector2_q;

    // Stage 4: outputs only move when a live sample arrives.
    sel = sector_map(sector3_q);
    rp  = pick(sel.r, c3_q, x3);
    gp  = pick(sel.g, c3_q, x3);
    bp  = pick(sel.b, c3_q, x3);
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (vld_q[LATENCY-2]) begin
      r_d = sat_add8(rp, m3_q);
      g_d = sat_add8(gp, m3_q);
      b_d = sat_add8(bp, m3_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      d1_q      <= '0;
      sector1_q <= '0;
      f1_q      <= '0;
      s1_q      <= '0;
      l1_q      <= '0;
      hp2_q     <= '0;
      l2_q      <= '0;
      sector2_q <= '0;
      m3_q      <= '0;
      c3_q      <= '0;
      sector3_q <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      vld_q     <= vld_d;
      d1_q      <= d1_d;
      sector1_q <= sector1_d;
      f1_q      <= f1_d;
      s1_q      <= s1_d;
      l1_q      <= l1_d;
      hp2_q     <= hp2_d;
      l2_q      <= l2_d;
      sector2_q <= sector2_d;
      m3_q      <= m3_d;
      c3_q      <= c3_d;
      sector3_q <= sector3_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign r       = r_q;
  assign g       = g_q;
  assign b       = b_q;
  assign valid_o = vld_q[LATENCY-1];

endmodule

// File: tb/tb_hsl_to_rgb.sv
module tb_hsl_to_rgb;

  logic       clock;
  logic       reset;
  logic [7:0] h, s, l;
  logic       ready_i;
  logic [7:0] r, g, b;
  logic       valid_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    bit          lit;
    logic [23:0] lv;
  } exp_t;

  exp_t        q[$];
  logic [23:0] held;
  bit          lit_en;
  logic [23:0] lit_val;

  hsl_to_rgb dut (
    .clock   (clock),
    .reset   (reset),
    .h       (h),
    .s       (s),
    .l       (l),
    .ready_i (ready_i),
    .r       (r),
    .g       (g),
    .b       (b),
    .valid_o (valid_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Reference: straight HSL formulas with integer rounding to nearest.
  function automatic logic [23:0] model(input int hh, input int ss, input int ll);
    int d, c, sec, f, hp, x, m, rp, gp, bp;
    d = 2 * ll - 255;
    if (d < 0) d = -d;
    c   = ((255 - d) * ss + 127) / 255;
    sec = (hh * 6) / 256;
    f   = (hh * 6) % 256;
    hp  = (sec % 2 == 1) ? 255 - f : f;
    x   = (c * hp + 127) / 255;
    m   = ll - c / 2;
    rp = 0; gp = 0; bp = 0;
    case (sec)
      0: begin rp = c; gp = x; end
      1: begin rp = x; gp = c; end
      2: begin gp = c; bp = x; end
      3: begin gp = x; bp = c; end
      4: begin rp = x; bp = c; end
      default: begin rp = c; bp = x; end
    endcase
    return {8'(sat(rp + m)), 8'(sat(gp + m)), 8'(sat(bp + m))};
  endfunction

  // Record each accepted input with the cycle its result must appear.
  always @(posedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
    end else if (ready_i) begin
      e.due = cyc + 3;
      e.rgb = model(int'(h), int'(s), int'(l));
      e.lit = lit_en;
      e.lv  = lit_val;
      q.push_back(e);
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_v;
    if (reset) begin
      q.delete();
      held = '0;
      chk("reset_valid", 32'(valid_o), 32'd0);
      chk("reset_rgb", 32'({r, g, b}), 32'd0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("pulse_missing", 32'(q[0].due), 32'(cyc));
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("valid", 32'(valid_o), 32'(exp_v));
      if (exp_v) begin
        e    = q.pop_front();
        held = e.rgb;
        if (e.lit) chk("literal_rgb", 32'({r, g, b}), 32'(e.lv));
      end
      chk("rgb", 32'({r, g, b}), 32'(held));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input int hh, input int ss, input int ll,
                       input bit lit, input logic [23:0] lv);
    if (lit) chk("model_pin", 32'(model(hh, ss, ll)), 32'(lv));
    h       = 8'(hh);
    s       = 8'(ss);
    l       = 8'(ll);
    ready_i = 1'b1;
    lit_en  = lit;
    lit_val = lv;
    tick();
    ready_i = 1'b0;
    lit_en  = 1'b0;
    h       = 8'($urandom);
    s       = 8'($urandom);
    l       = 8'($urandom);
  endtask

  initial begin
    h = '0; s = '0; l = '0;
    ready_i = 1'b0;
    lit_en  = 1'b0;
    lit_val = '0;
    held    = '0;
    reset   = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    drive(128, 255, 130, 1'b1, {8'd5,   8'd255, 8'd255});
    idle(6);
    drive(0,   255, 128, 1'b1, {8'd255, 8'd1,   8'd1});
    idle(6);
    drive(43,  255, 128, 1'b1, {8'd253, 8'd255, 8'd1});
    idle(6);
    drive(200, 0,   77,  1'b1, {8'd77,  8'd77,  8'd77});
    idle(5);
    drive(10,  255, 255, 1'b1, {8'd255, 8'd255, 8'd255});
    idle(5);
    drive(99,  200, 0,   1'b1, {8'd0,   8'd0,   8'd0});
    idle(6);

    // Back-to-back strobes, then hold of the last result.
    drive(0,   255, 128, 1'b1, {8'd255, 8'd1,   8'd1});
    drive(128, 255, 130, 1'b1, {8'd5,   8'd255, 8'd255});
    drive(43,  255, 128, 1'b1, {8'd253, 8'd255, 8'd1});
    idle(8);

    // Hue sweep across all sectors with varied s and l, back-to-back.
    for (int i = 0; i < 16; i++) begin
      drive(i * 17, 255 - i * 13, 40 + i * 11, 1'b0, '0);
    end
    idle(8);

    // Reset two cycles after a strobe: in-flight sample must vanish.
    drive(0, 255, 128, 1'b0, '0);
    tick();
    reset = 1'b1;
    #2;
    chk("mid_reset_valid", 32'(valid_o), 32'd0);
    chk("mid_reset_rgb", 32'({r, g, b}), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(6);

    drive(128, 255, 130, 1'b1, {8'd5, 8'd255, 8'd255});
    idle(6);

    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
